// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the ALU-only datapath.
// Optional perf counters (cycle_cnt, instret) are built only with ALU_SEQ_PERF_EN defined.
module alu_seq_ctrl #(
  parameter logic [31:0] PC_RESET        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   legal, is_ebreak, skip_illegal;

  assign legal        = (instr[6:0] == 7'b0010011) || (instr[6:0] == 7'b0110011);
  assign is_ebreak    = (instr == 32'h0010_0073);
  assign skip_illegal = (state == DECODE) && !legal && !is_ebreak;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH:  if (imem_ack) state_nxt = DECODE;
      DECODE: begin
        if (legal)                state_nxt = EXEC;
        else if (is_ebreak)       state_nxt = HALT;
        else if (HALT_ON_ILLEGAL) state_nxt = HALT;
        else                      state_nxt = run ? FETCH : IDLE;
      end
      EXEC:   state_nxt = WB;
      WB:     state_nxt = run ? FETCH : IDLE;
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH);
    rf_we    = (state == WB) && (instr[11:7] != 5'd0);
    busy     = (state != IDLE) && (state != HALT);
    halted   = (state == HALT);
  end

  assign imem_addr = pc;

  // Only the word index advances, so pc[1:0] keeps its reset value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc      <= PC_RESET;
      instr   <= 32'd0;
      illegal <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (skip_illegal) begin
        illegal <= 1'b1;
        if (!HALT_ON_ILLEGAL) pc <= {pc[31:2] + 30'd1, pc[1:0]};
      end
      if (state == WB) pc <= {pc[31:2] + 30'd1, pc[1:0]};
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      if (state != HALT) cyc_q <= cyc_q + 32'd1;
      if (state == WB)   ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instret   = ret_q;
`else
  assign cycle_cnt = 32'd0;
  assign instret   = 32'd0;
`endif

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer for the ALU-only datapath. It fetches instructions from instruction memory over a request/acknowledge handshake, holds each instruction stable for the decoder, regfile and ALU, and gates the register-file write to one cycle per instruction. It advances the PC, detects unsupported opcodes and `EBREAK`, and sits between instruction memory and the decode/regfile/ALU path.

## Interface
- `PC_RESET`, default `32'h0000_0000`: PC value loaded on reset.
- `HALT_ON_ILLEGAL`, default `1`:
  - `1`: an illegal instruction halts the sequencer.
  - `0`: an illegal instruction is skipped; the PC advances by 4 and nothing is written.

- `clk`  in  1  Single clock; all state changes on the rising edge.
- `reset_n`  in  1  Synchronous, active-low reset.
- `run`  in  1  Level. While high, the sequencer keeps issuing instructions.
- `imem_req`  out  1  Fetch request.
- `imem_addr`  out  32  Fetch address; equals `pc`.
- `imem_ack`  in  1  Fetch data valid on `imem_rdata` this cycle.
- `imem_rdata`  in  32  Fetched instruction word.
- `instr`  out  32  Latched instruction, driven to the decoder.
- `rf_we`  out  1  Register-file write strobe, high for exactly one cycle.
- `pc`  out  32  Current program counter.
- `busy`  out  1  High in every state except IDLE and HALT.
- `halted`  out  1  High in HALT.
- `illegal`  out  1  Sticky flag: at least one illegal instruction has been seen.
- `cycle_cnt`  out  32  Cycles since reset (see Configuration).
- `instret`  out  32  Instructions retired (see Configuration).

## Operation
States: IDLE, FETCH, DECODE, EXEC, WB, HALT.

Transitions:
- IDLE → FETCH when `run`=1.
- FETCH: `imem_req`=1. Stay until `imem_ack`=1. On ack, latch `imem_rdata` into `instr` and go to DECODE.
- DECODE: classify `instr`. Legal means `instr[6:0]` is `7'b0010011` (OP-IMM) or `7'b0110011` (OP).
  - Legal: go to EXEC.
  - `instr`==`32'h0010_0073` (EBREAK): go to HALT; PC unchanged.
  - Any other opcode: set `illegal`.
    - `HALT_ON_ILLEGAL`=1: go to HALT.
    - `HALT_ON_ILLEGAL`=0: `pc` ← `pc`+4, go to FETCH if `run` else IDLE. No write.
- EXEC: one settle cycle for regfile read and ALU. Go to WB.
- WB:
  - `rf_we`=1, except `rf_we`=0 when `instr[11:7]`==0 (x0 is never written).
  - `pc` ← `pc`+4; `instret` increments.
  - Next state FETCH if `run`=1, else IDLE.
- HALT: absorbing. Only `reset_n`=0 leaves it.

Arithmetic and width:
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC`+4 wraps to 0.
- `pc[1:0]` is never modified; `PC_RESET` must be word-aligned.
- The counters wrap modulo 2^32.

`instr`, `pc`, `illegal` hold their values in every state in which they are not explicitly updated.

## Timing
- Reset (`reset_n` sampled low at an edge) drives the following on the next cycle:
  - state IDLE, `pc`=`PC_RESET`, `instr`=0, `illegal`=0, counters 0;
  - `imem_req`=0, `rf_we`=0, `busy`=0, `halted`=0.
- Reset mid-operation aborts immediately from any state. An `imem_ack` in the same cycle as reset is ignored.
- Per-instruction latency with zero-wait memory (ack in the first FETCH cycle) is 4 cycles: FETCH, DECODE, EXEC, WB. Each memory wait cycle adds one.
- Fetch handshake:
  - `imem_addr` is stable while `imem_req`=1.
  - `imem_ack` is only honoured in FETCH; acks in other states are ignored.
  - `imem_req` deasserts in the cycle after the accepting ack.
- `run` is sampled only in IDLE and at the exit of WB or an illegal skip. Dropping `run` never aborts an instruction in flight.
- `rf_we` is registered-state decoded: it is high only during the WB cycle.
- `instr` is stable from DECODE through WB.

## Configuration
- `ALU_SEQ_PERF_EN` defined:
  - `cycle_cnt` increments every cycle that `reset_n`=1 and state ≠ HALT.
  - `instret` increments once per WB cycle.
- `ALU_SEQ_PERF_EN` undefined:
  - Both ports are tied to 0 and no counter registers are built.
  - All other behaviour is identical.

## Test plan
- Zero-wait stream `ADDI x1,x0,5` (`32'h0050_0093`), `ADD x2,x1,x1` (`32'h0010_8133`), `run`=1.
  - `rf_we` pulses in cycles 4 and 8 after leaving IDLE.
  - `pc` goes 0→4→8.
  - `instret`=2 (with PERF).
- Memory ack delayed 3 cycles: `imem_req` and `imem_addr` are held for 4 cycles, and the instruction completes at cycle 7.
- `ADDI x0,x0,1` (`32'h0010_0013`): WB state is reached with `rf_we`=0 and `pc` advances by 4.
- Illegal word `32'h0000_0003` with `HALT_ON_ILLEGAL`=1: `illegal`=1, `halted`=1, `pc` frozen.
  - With `HALT_ON_ILLEGAL`=0: `pc` advances by 4, no `rf_we`, and the next fetch is issued.
- `EBREAK` halts. Then `reset_n` is pulled low mid-FETCH of a new run.
  - Next cycle: `pc`=`PC_RESET`, `imem_req`=0, `halted`=0, counters 0.
- `run` dropped during EXEC: WB completes, state goes to IDLE, and no new `imem_req` is issued until `run` returns high.
- `PC_RESET`=`32'hFFFF_FFFC`: after one instruction, `pc`=0.
